// File: rtl/mspe_pkg.sv
// Shared types for the MSPE source-side packet arbiter.
package mspe_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_BODY} arb_state_e;

  localparam int unsigned HDR_LEN_LSB = 0;

endpackage

// File: rtl/mspe_src_arbiter_if.sv
// Streaming source port: one beat per valid&ready with sop/eop framing and owning channel.
interface mspe_src_arbiter_if #(
  parameter int unsigned DW = 512,
  parameter int unsigned CH = 4
);
  logic [DW-1:0]         src_data;
  logic                  src_valid;
  logic                  src_sop;
  logic                  src_eop;
  logic                  src_ready;
  logic [$clog2(CH)-1:0] src_channel;

  modport master (output src_data, src_valid, src_sop, src_eop, src_channel, input src_ready);
  modport slave  (input src_data, src_valid, src_sop, src_eop, src_channel, output src_ready);
endinterface

// File: rtl/mspe_rr_pick.sv
// Combinational rotating-priority encoder: first requester at or after i_ptr wins.
module mspe_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_gnt_valid,
  output logic [$clog2(N)-1:0] o_gnt_idx
);

  always_comb begin : p_pick
    int unsigned k;
    k           = 0;
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(i_ptr) + i) % N;
      if (!o_gnt_valid && i_req[k[$clog2(N)-1:0]]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = k[$clog2(N)-1:0];
      end
    end
  end

endmodule

// File: rtl/mspe_src_arbiter.sv
// Packet-level arbiter: pulls length-prefixed packets from per-core FWFT FIFOs and
// serialises them onto one sop/eop stream with rotating priority and full backpressure.
module mspe_src_arbiter
  import mspe_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned DW       = 512,
  parameter int unsigned CW       = 32,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MAX_LEN  = 255,
  parameter int unsigned HDR_EMIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [CH*CW-1:0]     ch_count,
  input  logic [CH*DW-1:0]     ch_data,
  output logic [CH-1:0]        ch_re,
  mspe_src_arbiter_if.master   src,
  output logic                 busy,
  output logic [CH-1:0]        err_len,
  output logic [31:0]          pkt_count
);

  localparam int unsigned CHW = $clog2(CH);
  localparam int unsigned CW1 = CW + 1;

  arb_state_e       r_state, w_state_nx;
  logic [CHW-1:0]   r_ptr, w_ptr_nx, r_ch, w_ch_nx;
  logic [LEN_W-1:0] r_rem, w_rem_nx;
  logic             r_first, w_first_nx;

  logic             r_valid, r_sop, r_eop;
  logic [DW-1:0]    r_data;
  logic [CHW-1:0]   r_src_ch;
  logic [CH-1:0]    r_err_len, w_err_set;
  logic [31:0]      r_pkt_count;

  logic             w_free, w_load, w_ld_sop, w_ld_eop, w_hdr_bad;
  logic [DW-1:0]    w_ld_data;
  logic [CHW-1:0]   w_ld_ch;
  logic [CH-1:0]    w_ch_re;

  logic [DW-1:0]    w_word [CH];
  logic [LEN_W-1:0] w_len  [CH];
  logic [CH-1:0]    w_elig;
  logic             w_gnt_valid;
  logic [CHW-1:0]   w_gnt_idx;
  logic [LEN_W-1:0] w_pick_len;

  // A channel is eligible only once its whole packet (header + N beats) is buffered.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign w_word[k] = ch_data[k*DW +: DW];
    assign w_len[k]  = w_word[k][HDR_LEN_LSB +: LEN_W];
    assign w_elig[k] = {1'b0, ch_count[k*CW +: CW]} >= (CW1'(w_len[k]) + CW1'(1));
  end

  mspe_rr_pick #(.N(CH)) u_pick (
    .i_req       (w_elig),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_free     = !r_valid || src.src_ready;
  assign w_pick_len = w_len[w_gnt_idx];
  assign w_hdr_bad  = 32'(w_pick_len) > MAX_LEN;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_ch_nx    = r_ch;
    w_rem_nx   = r_rem;
    w_first_nx = r_first;
    w_ch_re    = '0;
    w_err_set  = '0;
    w_load     = 1'b0;
    w_ld_data  = '0;
    w_ld_sop   = 1'b0;
    w_ld_eop   = 1'b0;
    w_ld_ch    = r_ch;
    case (r_state)
      ST_IDLE: begin
        if (en && w_free && w_gnt_valid) begin
          w_ch_re[w_gnt_idx] = 1'b1;
          w_ptr_nx = (32'(w_gnt_idx) == CH - 1) ? '0 : w_gnt_idx + CHW'(1);
          w_ch_nx  = w_gnt_idx;
          if (w_hdr_bad) begin
            w_err_set[w_gnt_idx] = 1'b1;
          end else if (HDR_EMIT != 0) begin
            w_load    = 1'b1;
            w_ld_data = w_word[w_gnt_idx];
            w_ld_sop  = 1'b1;
            w_ld_eop  = (w_pick_len == '0);
            w_ld_ch   = w_gnt_idx;
            if (w_pick_len != '0) begin
              w_state_nx = ST_BODY;
              w_rem_nx   = w_pick_len;
              w_first_nx = 1'b0;
            end
          end else if (w_pick_len != '0) begin
            w_state_nx = ST_BODY;
            w_rem_nx   = w_pick_len;
            w_first_nx = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (w_free) begin
          w_ch_re[r_ch] = 1'b1;
          w_load        = 1'b1;
          w_ld_data     = w_word[r_ch];
          w_ld_sop      = r_first && (HDR_EMIT == 0);
          w_ld_eop      = (r_rem == LEN_W'(1));
          w_ld_ch       = r_ch;
          w_rem_nx      = r_rem - LEN_W'(1);
          w_first_nx    = 1'b0;
          if (r_rem == LEN_W'(1)) w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_rem   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_ch    <= w_ch_nx;
      r_rem   <= w_rem_nx;
      r_first <= w_first_nx;
    end
  end

  // Output register only moves when the slot is free, so a stalled beat stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_src_ch <= '0;
    end else if (w_free) begin
      r_valid <= w_load;
      if (w_load) begin
        r_data   <= w_ld_data;
        r_sop    <= w_ld_sop;
        r_eop    <= w_ld_eop;
        r_src_ch <= w_ld_ch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_len   <= '0;
      r_pkt_count <= '0;
    end else begin
      r_err_len <= r_err_len | w_err_set;
      if (r_valid && src.src_ready && r_eop) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign ch_re           = w_ch_re;
  assign src.src_valid   = r_valid;
  assign src.src_data    = r_data;
  assign src.src_sop     = r_sop;
  assign src.src_eop     = r_eop;
  assign src.src_channel = r_src_ch;
  assign busy            = (r_state != ST_IDLE) || r_valid;
  assign err_len         = r_err_len;
  assign pkt_count       = r_pkt_count;

endmodule
